// File: rtl/matrix_pe_param_if.sv
// Bus bundle for matrix_pe_param: neuron beats from NRAM, weight beats from
// WRAM, uops from the instruction buffer, and the result/vld_o pair back.
//   master : the environment (drives beats/uops, observes readies and result)
//   slave  : the PE (drives readies, result and vld_o)
interface matrix_pe_param_if #(
  parameter int LANES = 32,
  parameter int DW    = 16,
  parameter int CNT_W = 6,
  parameter int ACC_W = 32
);
  logic [LANES*DW-1:0] nram_mpe_neuron;
  logic                nram_mpe_neuron_valid;
  logic                nram_mpe_neuron_ready;
  logic [LANES*DW-1:0] wram_mpe_weight;
  logic                wram_mpe_weight_valid;
  logic                wram_mpe_weight_ready;
  logic [CNT_W+1:0]    ib_ctl_uop;
  logic                ib_ctl_uop_valid;
  logic                ib_ctl_uop_ready;
  logic [ACC_W-1:0]    result;
  logic                vld_o;

  modport master (
    output nram_mpe_neuron, nram_mpe_neuron_valid,
    input  nram_mpe_neuron_ready,
    output wram_mpe_weight, wram_mpe_weight_valid,
    input  wram_mpe_weight_ready,
    output ib_ctl_uop, ib_ctl_uop_valid,
    input  ib_ctl_uop_ready,
    input  result, vld_o
  );

  modport slave (
    input  nram_mpe_neuron, nram_mpe_neuron_valid,
    output nram_mpe_neuron_ready,
    input  wram_mpe_weight, wram_mpe_weight_valid,
    output wram_mpe_weight_ready,
    input  ib_ctl_uop, ib_ctl_uop_valid,
    output ib_ctl_uop_ready,
    output result, vld_o
  );
endinterface

// File: rtl/matrix_pe_param.sv
// matrix_pe_param: parametrised dot-product PE.
// A uop {half_mode, sat_en, N} starts a run of N paired neuron/weight beats
// (N=0 means 2^CNT_W). Each pair's signed lane products are summed into a
// stage register, then accumulated; the final sum is emitted on result with a
// one-cycle vld_o, wrapped or saturated to ACC_W bits.
// Ports: clk, rst_n (async, active low), bus (matrix_pe_param_if.slave).

// One lane: full DWxDW signed product, or in half mode the sum of the two
// signed DW/2 sub-lane products.
module matrix_pe_lane #(
  parameter int DW = 16
) (
  input  logic [DW-1:0]   neuron,
  input  logic [DW-1:0]   weight,
  input  logic            half_mode,
  output logic [2*DW-1:0] prod
);
  localparam int HW = DW / 2;
  localparam int PW = 2 * DW;

  logic signed [PW-1:0] nf, wf, nl, wl, nh, wh;

  always_comb begin
    nf   = {{DW{neuron[DW-1]}}, neuron};
    wf   = {{DW{weight[DW-1]}}, weight};
    nl   = {{(PW-HW){neuron[HW-1]}}, neuron[HW-1:0]};
    wl   = {{(PW-HW){weight[HW-1]}}, weight[HW-1:0]};
    nh   = {{(PW-HW){neuron[DW-1]}}, neuron[DW-1:HW]};
    wh   = {{(PW-HW){weight[DW-1]}}, weight[DW-1:HW]};
    prod = half_mode ? (nl * wl + nh * wh) : (nf * wf);
  end
endmodule

module matrix_pe_param #(
  parameter int LANES = 32,
  parameter int DW    = 16,
  parameter int CNT_W = 6,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  matrix_pe_param_if.slave   bus
);
  localparam int PW = 2 * DW;
  localparam int SW = PW + $clog2(LANES);
  localparam int AW = SW + CNT_W + 1;   // wide enough for 2^CNT_W full beats
  localparam logic signed [AW-1:0] MAXV = {{(AW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;

  state_e                state_q, state_d;
  logic [CNT_W:0]        rem_q, rem_d;
  logic                  sat_q, sat_d, half_q, half_d;
  logic                  stg_vld_q, stg_vld_d;
  logic                  vld_q, vld_d;
  logic                  uop_rdy_q, uop_rdy_d;
  logic signed [SW-1:0]  stage_q, stage_d, lane_sum;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]      result_q, result_d, fmt;
  logic [LANES-1:0][PW-1:0] prod;
  logic                  pair_fire;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    matrix_pe_lane #(.DW(DW)) u_lane (
      .neuron    (bus.nram_mpe_neuron[i*DW +: DW]),
      .weight    (bus.wram_mpe_weight[i*DW +: DW]),
      .half_mode (half_q),
      .prod      (prod[i])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++)
      lane_sum = lane_sum + $signed({{(SW-PW){prod[i][PW-1]}}, prod[i]});
  end

  always_comb begin
    if (sat_q && acc_q > MAXV)      fmt = MAXV[ACC_W-1:0];
    else if (sat_q && acc_q < MINV) fmt = MINV[ACC_W-1:0];
    else                            fmt = acc_q[ACC_W-1:0];
  end

  // Each side's ready mirrors the other side's valid so beats only ever
  // transfer as a pair.
  assign pair_fire = (state_q == RUN) && bus.nram_mpe_neuron_valid && bus.wram_mpe_weight_valid;
  assign bus.nram_mpe_neuron_ready = (state_q == RUN) && bus.wram_mpe_weight_valid;
  assign bus.wram_mpe_weight_ready = (state_q == RUN) && bus.nram_mpe_neuron_valid;
  assign bus.ib_ctl_uop_ready      = uop_rdy_q;
  assign bus.result                = result_q;
  assign bus.vld_o                 = vld_q;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    sat_d     = sat_q;
    half_d    = half_q;
    result_d  = result_q;
    vld_d     = 1'b0;
    stg_vld_d = pair_fire;
    stage_d   = pair_fire ? lane_sum : stage_q;
    acc_d     = stg_vld_q ? acc_q + $signed({{(AW-SW){stage_q[SW-1]}}, stage_q}) : acc_q;
    case (state_q)
      IDLE: if (uop_rdy_q && bus.ib_ctl_uop_valid) begin
        rem_d   = {~|bus.ib_ctl_uop[CNT_W-1:0], bus.ib_ctl_uop[CNT_W-1:0]};
        sat_d   = bus.ib_ctl_uop[CNT_W];
        half_d  = bus.ib_ctl_uop[CNT_W+1];
        acc_d   = '0;
        state_d = RUN;
      end
      RUN: if (pair_fire) begin
        rem_d = rem_q - 1'b1;
        if (rem_q == 1) state_d = DRAIN;
      end
      // The last stage value lands in acc one edge after DRAIN is entered.
      DRAIN: if (!stg_vld_q) begin
        result_d = fmt;
        vld_d    = 1'b1;
        state_d  = OUT;
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    uop_rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      sat_q     <= 1'b0;
      half_q    <= 1'b0;
      stg_vld_q <= 1'b0;
      stage_q   <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      vld_q     <= 1'b0;
      uop_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      sat_q     <= sat_d;
      half_q    <= half_d;
      stg_vld_q <= stg_vld_d;
      stage_q   <= stage_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      vld_q     <= vld_d;
      uop_rdy_q <= uop_rdy_d;
    end
  end
endmodule

// File: tb/tb_matrix_pe_param.sv
// Self-checking bench for matrix_pe_param: random and directed uops checked
// against a plain-arithmetic dot-product model, plus latency, stall, reset
// abort and back-to-back scenarios.
module tb_matrix_pe_param;
  localparam int LANES = 32, DW = 16, CNT_W = 6, ACC_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  int   pairs = 0;

  logic [LANES*DW-1:0] nb [64];
  logic [LANES*DW-1:0] wb [64];
  logic [ACC_W-1:0]    vq[$];
  int                  vcq[$];

  matrix_pe_param_if #(.LANES(LANES), .DW(DW), .CNT_W(CNT_W), .ACC_W(ACC_W)) bus();

  matrix_pe_param #(.LANES(LANES), .DW(DW), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.vld_o === 1'b1) begin
    vq.push_back(bus.result);
    vcq.push_back(cyc);
  end

  function automatic logic [ACC_W-1:0] model(int n, bit sat, bit half);
    longint s = 0;
    int beats = (n == 0) ? 64 : n;
    logic [DW-1:0] a, w;
    for (int b = 0; b < beats; b++)
      for (int l = 0; l < LANES; l++) begin
        a = nb[b][l*DW +: DW];
        w = wb[b][l*DW +: DW];
        if (!half) s += longint'($signed(a)) * longint'($signed(w));
        else s += longint'($signed(a[7:0])) * longint'($signed(w[7:0]))
                + longint'($signed(a[15:8])) * longint'($signed(w[15:8]));
      end
    if (sat && s > 64'sd2147483647)  return 32'h7fffffff;
    if (sat && s < -64'sd2147483648) return 32'h80000000;
    return s[31:0];
  endfunction

  function automatic void fill_rand();
    for (int b = 0; b < 64; b++)
      for (int l = 0; l < LANES; l++) begin
        nb[b][l*DW +: DW] = DW'($urandom);
        wb[b][l*DW +: DW] = DW'($urandom);
      end
  endfunction

  function automatic void fill_const(logic [DW-1:0] a, logic [DW-1:0] w);
    for (int b = 0; b < 64; b++)
      for (int l = 0; l < LANES; l++) begin
        nb[b][l*DW +: DW] = a;
        wb[b][l*DW +: DW] = w;
      end
  endfunction

  // Issues one uop and its beats, then checks result and latency. Entered just
  // after a falling edge; returns shortly after the falling edge that saw vld_o.
  task automatic run_uop(input string nm, input int n, input bit sat, input bit half,
                         input int vp, input int stall, input int pre,
                         output logic [ACC_W-1:0] res, output int acc_cyc, output int vcyc);
    int beats = (n == 0) ? 64 : n;
    int k = 0, t = 0, bad = 0, last_cyc = -100;
    logic [ACC_W-1:0] expv;
    expv = model(n, sat, half);
    res = 'x; vcyc = -1; acc_cyc = -1;
    repeat (pre) @(negedge clk);
    bus.ib_ctl_uop = {half, sat, CNT_W'(n)};
    bus.ib_ctl_uop_valid = 1'b1;
    forever begin
      #1;
      if (bus.ib_ctl_uop_ready === 1'b1) break;
      @(negedge clk);
      if (++t > 50) break;
    end
    acc_cyc = cyc;
    @(negedge clk);
    bus.ib_ctl_uop_valid = 1'b0;
    for (int s = 0; s < stall; s++) begin
      bus.nram_mpe_neuron_valid = 1'b1;
      bus.wram_mpe_weight_valid = 1'b0;
      bus.ib_ctl_uop_valid = 1'b1;
      #1;
      if (bus.nram_mpe_neuron_ready !== 1'b0 || bus.ib_ctl_uop_ready !== 1'b0 || bus.vld_o !== 1'b0) bad++;
      @(negedge clk);
    end
    bus.ib_ctl_uop_valid = 1'b0;
    if (stall > 0) begin
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL %s stall: %0d bad cycles, want 0", nm, bad); end
    end
    t = 0;
    while (k < beats && t < 3000) begin
      bus.nram_mpe_neuron = nb[k];
      bus.wram_mpe_weight = wb[k];
      bus.nram_mpe_neuron_valid = ($urandom_range(99) < vp);
      bus.wram_mpe_weight_valid = ($urandom_range(99) < vp);
      #1;
      if (bus.nram_mpe_neuron_valid && bus.wram_mpe_weight_valid &&
          bus.nram_mpe_neuron_ready === 1'b1 && bus.wram_mpe_weight_ready === 1'b1) begin
        if (k == beats - 1) begin
          last_cyc = cyc;
          n_chk++;
          if (vq.size() != 0) begin n_fail++; $display("FAIL %s early_vld: %0d pulses before last beat, want 0", nm, vq.size()); end
        end
        k++;
        pairs++;
      end
      @(negedge clk);
      t++;
    end
    bus.nram_mpe_neuron_valid = 1'b0;
    bus.wram_mpe_weight_valid = 1'b0;
    for (int w = 0; w < 20; w++) begin
      #1;
      if (vq.size() > 0) break;
      @(negedge clk);
    end
    n_chk++;
    if (vq.size() == 0) begin
      n_fail++; $display("FAIL %s timeout: no vld_o, beats %0d of %0d", nm, k, beats);
    end else begin
      res = vq.pop_front();
      vcyc = vcq.pop_front();
      if (res !== expv) begin n_fail++; $display("FAIL %s result: got %0h want %0h", nm, res, expv); end
      n_chk++;
      if (vcyc !== last_cyc + 3) begin
        n_fail++; $display("FAIL %s latency: vld at cycle %0d want %0d", nm, vcyc, last_cyc + 3);
      end
    end
  endtask

  task automatic test_reset();
    bus.nram_mpe_neuron = '0; bus.wram_mpe_weight = '0; bus.ib_ctl_uop = '0;
    bus.nram_mpe_neuron_valid = 1'b0; bus.wram_mpe_weight_valid = 1'b0;
    bus.ib_ctl_uop_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    n_chk += 3;
    if (bus.vld_o !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %b want 0", bus.vld_o); end
    if (bus.result !== '0) begin n_fail++; $display("FAIL rst_result: got %0h want 0", bus.result); end
    if ({bus.ib_ctl_uop_ready, bus.nram_mpe_neuron_ready, bus.wram_mpe_weight_ready} !== 3'b000) begin
      n_fail++; $display("FAIL rst_ready: got %b want 000",
        {bus.ib_ctl_uop_ready, bus.nram_mpe_neuron_ready, bus.wram_mpe_weight_ready});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_chk++;
    if (bus.ib_ctl_uop_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", bus.ib_ctl_uop_ready); end
  endtask

  task automatic test_single();
    logic [ACC_W-1:0] r; int a, v;
    @(negedge clk);
    fill_const(16'd1, 16'd2);
    run_uop("single", 1, 1'b0, 1'b0, 100, 0, 0, r, a, v);
    n_chk++;
    if (r !== 32'd64) begin n_fail++; $display("FAIL single_const: got %0d want 64", r); end
  endtask

  task automatic test_random();
    logic [ACC_W-1:0] r; int a, v;
    @(negedge clk);
    pairs = 0;
    for (int u = 0; u < 4; u++) begin
      fill_rand();
      run_uop("random", 35, 1'($urandom), 1'b0, 60, 0, $urandom_range(3), r, a, v);
    end
    n_chk++;
    if (pairs !== 140) begin n_fail++; $display("FAIL random_pairs: got %0d want 140", pairs); end
  endtask

  task automatic test_half();
    logic [ACC_W-1:0] r; int a, v;
    @(negedge clk);
    fill_const(16'h007f, 16'h007f);
    run_uop("half_const", 1, 1'b0, 1'b1, 100, 0, 0, r, a, v);
    n_chk++;
    if (r !== 32'd516128) begin n_fail++; $display("FAIL half_value: got %0d want 516128", r); end
    for (int u = 0; u < 2; u++) begin
      fill_rand();
      run_uop("half_rand", 5, 1'b0, 1'b1, 70, 0, 1, r, a, v);
    end
  endtask

  task automatic test_sat();
    logic [ACC_W-1:0] r; int a, v;
    @(negedge clk);
    fill_const(16'h7fff, 16'h7fff);
    run_uop("sat_on", 0, 1'b1, 1'b0, 100, 0, 0, r, a, v);
    n_chk++;
    if (r !== 32'h7fffffff) begin n_fail++; $display("FAIL sat_clamp: got %0h want 7fffffff", r); end
    run_uop("sat_off", 0, 1'b0, 1'b0, 100, 0, 1, r, a, v);
    n_chk++;
    if (r !== 32'hf8000800) begin n_fail++; $display("FAIL sat_wrap: got %0h want f8000800", r); end
    fill_const(16'h8000, 16'h7fff);
    run_uop("sat_neg", 0, 1'b1, 1'b0, 100, 0, 1, r, a, v);
    n_chk++;
    if (r !== 32'h80000000) begin n_fail++; $display("FAIL sat_neg_clamp: got %0h want 80000000", r); end
  endtask

  task automatic test_stall();
    logic [ACC_W-1:0] r; int a, v;
    @(negedge clk);
    fill_rand();
    run_uop("stall", 4, 1'b0, 1'b0, 100, 10, 0, r, a, v);
  endtask

  task automatic test_back_to_back();
    logic [ACC_W-1:0] r; int a1, v1, a2, v2;
    @(negedge clk);
    fill_rand();
    run_uop("b2b_first", 2, 1'b0, 1'b0, 100, 0, 0, r, a1, v1);
    run_uop("b2b_second", 2, 1'b1, 1'b0, 100, 0, 0, r, a2, v2);
    n_chk++;
    if (a2 !== v1 + 1) begin n_fail++; $display("FAIL b2b_accept: uop at cycle %0d want %0d", a2, v1 + 1); end
  endtask

  task automatic test_abort();
    logic [ACC_W-1:0] r; int a, v, t;
    @(negedge clk);
    fill_rand();
    bus.ib_ctl_uop = {1'b0, 1'b0, CNT_W'(8)};
    bus.ib_ctl_uop_valid = 1'b1;
    t = 0;
    forever begin
      #1;
      if (bus.ib_ctl_uop_ready === 1'b1 || t > 50) break;
      @(negedge clk); t++;
    end
    @(negedge clk);
    bus.ib_ctl_uop_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.nram_mpe_neuron = nb[b]; bus.wram_mpe_weight = wb[b];
      bus.nram_mpe_neuron_valid = 1'b1; bus.wram_mpe_weight_valid = 1'b1;
      @(negedge clk);
    end
    bus.nram_mpe_neuron_valid = 1'b0; bus.wram_mpe_weight_valid = 1'b0;
    vq.delete(); vcq.delete();
    rst_n = 1'b0;
    #1;
    n_chk += 2;
    if (bus.result !== '0 || bus.vld_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_rst_out: result %0h vld %b want 0 0", bus.result, bus.vld_o);
    end
    if ({bus.ib_ctl_uop_ready, bus.nram_mpe_neuron_ready, bus.wram_mpe_weight_ready} !== 3'b000) begin
      n_fail++; $display("FAIL abort_rst_ready: got %b want 000",
        {bus.ib_ctl_uop_ready, bus.nram_mpe_neuron_ready, bus.wram_mpe_weight_ready});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    n_chk++;
    if (vq.size() != 0) begin n_fail++; $display("FAIL abort_vld: got %0d pulses want 0", vq.size()); end
    fill_rand();
    run_uop("after_abort", 1, 1'b0, 1'b0, 100, 0, 0, r, a, v);
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_half();
    test_sat();
    test_stall();
    test_back_to_back();
    test_abort();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
